// File: rtl/sweep_pattern_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sweep_pattern_if                                              |
// | Purpose  : Digit bus and checker status bundle for the sweep pattern     |
// |            checker.                                                      |
// | Signals  : pause, digit0..digit3 (8b active-low segment codes)  -> chk   |
// |            pos(2), dir, locked, err, err_count(ERR_W),                   |
// |            lap_count(LAP_W)                                    <- chk    |
// | Modports : master (pattern source / bench), slave (checker)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sweep_pattern_if #(
  parameter int ERR_W = 8,
  parameter int LAP_W = 8
);
  logic             pause;
  logic [7:0]       digit0;
  logic [7:0]       digit1;
  logic [7:0]       digit2;
  logic [7:0]       digit3;
  logic [1:0]       pos;
  logic             dir;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [LAP_W-1:0] lap_count;

  modport master (
    output pause, digit0, digit1, digit2, digit3,
    input  pos, dir, locked, err, err_count, lap_count
  );

  modport slave (
    input  pause, digit0, digit1, digit2, digit3,
    output pos, dir, locked, err, err_count, lap_count
  );
endinterface
`default_nettype wire

// File: rtl/sweep_pattern_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sweep_pattern_checker                                         |
// | Purpose  : Receive-side checker for the 4-digit sweep pattern. Samples   |
// |            the digit codes every clk_1HZ tick, decodes position/glyph,   |
// |            locks onto 0U..3U,3D..0D and flags/counts deviations and laps.|
// | Ports    : clk_1HZ  in  tick clock (posedge)                             |
// |            rst      in  synchronous active-high reset                    |
// |            bus      slave modport of sweep_pattern_if                    |
// |              pause, digit0..3 in; pos, dir, locked, err,                 |
// |              err_count, lap_count out (all registered)                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sweep_pattern_checker #(
  parameter logic [7:0] UP_CODE   = 8'b00111001,
  parameter logic [7:0] DOWN_CODE = 8'b11000101,
  parameter logic [7:0] OFF_CODE  = 8'b11111111,
  parameter int         ERR_W     = 8,
  parameter int         LAP_W     = 8
) (
  input  wire logic     clk_1HZ,
  input  wire logic     rst,
  sweep_pattern_if.slave bus
);

  localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};
  localparam logic [LAP_W-1:0] c_LAP_MAX = {LAP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [1:0]       r_pos,       w_pos_nxt;
  logic             r_dir,       w_dir_nxt;
  logic             r_err,       w_err_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
  logic [LAP_W-1:0] r_lap_count, w_lap_count_nxt;

  // ---------------------------------------------------------------- decode
  logic [7:0] w_digits [4];
  logic [2:0] w_lit_cnt;
  logic [7:0] w_lit_code;
  logic [1:0] w_lit_pos;
  logic       w_valid;
  logic       w_frame_dir;

  assign w_digits[0] = bus.digit0;
  assign w_digits[1] = bus.digit1;
  assign w_digits[2] = bus.digit2;
  assign w_digits[3] = bus.digit3;

  // Count non-blank digits and remember the (last) lit one; only the
  // single-lit case is ever used, so "last" is unambiguous there.
  always_comb begin
    w_lit_cnt  = 3'd0;
    w_lit_code = OFF_CODE;
    w_lit_pos  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_digits[i] != OFF_CODE) begin
        w_lit_cnt  = w_lit_cnt + 3'd1;
        w_lit_code = w_digits[i];
        w_lit_pos  = 2'(i);
      end
    end
  end

  assign w_valid     = (w_lit_cnt == 3'd1) &&
                       ((w_lit_code == UP_CODE) || (w_lit_code == DOWN_CODE));
  assign w_frame_dir = (w_lit_code == DOWN_CODE);

  // -------------------------------------------------------- expected frame
  logic [1:0] w_exp_pos;
  logic       w_exp_dir;
  logic       w_match;
  logic       w_lap_edge;

  // While paused the source holds its frame, so the expectation is the
  // registered frame itself; otherwise it is the sweep successor.
  always_comb begin
    w_exp_pos = r_pos;
    w_exp_dir = r_dir;
    if (!bus.pause) begin
      if (!r_dir) begin
        if (r_pos == 2'd3) w_exp_dir = 1'b1;
        else               w_exp_pos = r_pos + 2'd1;
      end else begin
        if (r_pos == 2'd0) w_exp_dir = 1'b0;
        else               w_exp_pos = r_pos - 2'd1;
      end
    end
  end

  assign w_match    = w_valid && (w_lit_pos == w_exp_pos) && (w_frame_dir == w_exp_dir);
  // 0D -> 0U turn-around; qualified with w_match where used.
  assign w_lap_edge = !bus.pause && (r_pos == 2'd0) && r_dir &&
                      (w_lit_pos == 2'd0) && !w_frame_dir;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_1HZ) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pos       <= 2'd0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_lap_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_lap_count <= w_lap_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_dir_nxt       = r_dir;
    w_err_nxt       = 1'b0;
    w_err_count_nxt = r_err_count;
    w_lap_count_nxt = r_lap_count;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt = ST_SYNC;
          w_pos_nxt   = w_lit_pos;
          w_dir_nxt   = w_frame_dir;
        end
      end
      ST_SYNC: begin
        if (w_valid) begin
          // A non-matching valid frame re-seeds the expectation.
          w_pos_nxt = w_lit_pos;
          w_dir_nxt = w_frame_dir;
          if (w_match) w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_match) begin
          w_pos_nxt = w_lit_pos;
          w_dir_nxt = w_frame_dir;
          if (w_lap_edge && (r_lap_count != c_LAP_MAX))
            w_lap_count_nxt = r_lap_count + 1'b1;
        end else begin
          w_err_nxt = 1'b1;
          if (r_err_count != c_ERR_MAX)
            w_err_count_nxt = r_err_count + 1'b1;
          if (w_valid) begin
            w_state_nxt = ST_SYNC;
            w_pos_nxt   = w_lit_pos;
            w_dir_nxt   = w_frame_dir;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- outputs
  assign bus.pos       = r_pos;
  assign bus.dir       = r_dir;
  assign bus.locked    = (r_state == ST_LOCKED);
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.lap_count = r_lap_count;

endmodule
`default_nettype wire
